data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, giving the extra wait cycles between request accept and response (legal 0..15).
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1, a synchronous active-low reset.
REQ-004 The block SHALL have port req_valid, input, 1, meaning the initiator presents a request.
REQ-005 The block SHALL have port req_ready, output, 1, meaning the block can accept a request.
REQ-006 The block SHALL have port req_rw, input, 1, where 1 means write and 0 means read.
REQ-007 The block SHALL have port req_size, input, 2, encoded as 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 The block SHALL have port req_se, input, 1, requesting sign extension of byte and halfword reads.
REQ-009 The block SHALL have port req_addr, input, 9, the byte address.
REQ-010 The block SHALL have port req_wdata, input, 32, the write data, right-aligned.
REQ-011 The block SHALL have port rsp_valid, output, 1, meaning a response is presented.
REQ-012 The block SHALL have port rsp_ready, input, 1, meaning the initiator accepts the response.
REQ-013 The block SHALL have port rsp_rdata, output, 32, the read data, right-aligned.
REQ-014 The block SHALL have port rsp_err, output, 1, the access-error flag.
REQ-015 The block SHALL have port busy, output, 1, asserted whenever the state is not IDLE.

Function
REQ-016 Storage SHALL be 512 bytes, big-endian: byte at addr is the most significant byte of a multi-byte access.
REQ-017 The FSM SHALL have states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 A request SHALL be accepted on a clock where req_valid=1 and req_ready=1; all req_* fields SHALL be latched at that edge.
REQ-019 After accept, the FSM SHALL go IDLE->WAIT when WAIT_CYCLES>0, and directly IDLE->RESP when WAIT_CYCLES=0.
REQ-020 The WAIT counter SHALL load WAIT_CYCLES-1 on entry, decrement each cycle, and exit to RESP after it reaches 0, so rsp_valid first rises WAIT_CYCLES+1 cycles after the accept edge.
REQ-021 A write SHALL update storage on the edge entering RESP, writing only the bytes selected by size.
REQ-022 A read SHALL sample storage on the same edge and register the result into rsp_rdata.
REQ-023 rsp_valid, rsp_rdata and rsp_err SHALL hold stable in RESP until rsp_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-024 At most one request SHALL be outstanding; a new request SHALL NOT be accepted in the cycle rsp_valid handshakes, and IDLE is re-entered first.
REQ-025 For byte and halfword reads, upper bits SHALL be the sign of the read data when the latched se=1, and zero otherwise.
REQ-026 Write responses SHALL return rsp_rdata=0.
REQ-027 Byte address arithmetic SHALL wrap modulo 512, so a word at 0x1FE touches bytes 0x1FE, 0x1FF, 0x000, 0x001.
REQ-028 Reserved size 11 SHALL be treated as word.

Reset
REQ-029 When reset=0 at a clock edge, the state SHALL become IDLE, the counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0 and busy 0, and req_ready SHALL be 1 from the next cycle.
REQ-030 Reset asserted in WAIT or RESP SHALL discard the pending request; a write not yet committed SHALL NOT occur.
REQ-031 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-032 With macro DMEM_MISALIGN_TRAP_EN defined, halfword with addr[0]!=0, word with addr[1:0]!=0, and size 11 SHALL produce rsp_err=1 and rsp_rdata=0, with no storage write and unchanged timing.
REQ-033 Without DMEM_MISALIGN_TRAP_EN, rsp_err SHALL be tied to 0 and misaligned accesses SHALL proceed per REQ-027 and REQ-028.

Structure
REQ-034 A shared package SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state encoding, and the storage depth constant 512.
REQ-035 The byte storage SHALL be one sub-module, dmem_array, with four byte-lane read/write ports addressed addr+0..3 modulo 512.

Verification
REQ-036 Word write then word read: write 0xDEADBEEF to 0x010, then read word 0x010 -> rdata=0xDEADBEEF, with rsp_valid rising 3 cycles after accept (WAIT_CYCLES=2).
REQ-037 Byte read with sign extension: read byte 0x010 with se=1 -> rdata=0xFFFFFFDE; with se=0 -> 0x000000DE; halfword 0x012 with se=1 -> 0xFFFFBEEF.
REQ-038 Response backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stay stable, req_ready=0 throughout, and the next request is accepted only after IDLE.
REQ-039 Wrap-around: write word 0x11223344 at 0x1FE -> byte 0x1FF=0x22 and byte 0x000=0x33; read word 0x1FE -> 0x11223344 (macro undefined).
REQ-040 Misaligned access with macro DMEM_MISALIGN_TRAP_EN defined: write word 0x55 at 0x011 -> rsp_err=1 and rdata=0, and a following read of word 0x010 -> unchanged 0xDEADBEEF.
REQ-041 Reset mid-write: drive reset=0 during WAIT of a write of 0xCAFEF00D to 0x020 -> busy=0 next cycle, and a read of word 0x020 returns its prior value.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared size encodings, FSM states and storage geometry
package data_mem_responder_pkg;
  localparam int DEPTH = 512;
  localparam int AW = 9;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response bus between initiator (master) and responder (slave)
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [1:0]  req_size;
  logic        req_se;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  modport master (
    output req_valid, req_rw, req_size, req_se, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_rw, req_size, req_se, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder_dmem.sv
// dmem_array: 512-byte storage with four byte lanes at addr+0..3 (mod 512)
// Ports: clk; addr base byte address; we per-lane write enable;
//        wdata/rdata per-lane bytes (lane i is byte addr+i, read is combinational).
module dmem_array
  import data_mem_responder_pkg::*;
(
  input  logic                clk,
  input  logic [AW-1:0]       addr,
  input  logic [3:0]          we,
  input  logic [3:0][7:0]     wdata,
  output logic [3:0][7:0]     rdata
);
  logic [7:0] mem [DEPTH];
  // 9-bit lane addresses wrap naturally modulo 512
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[addr + AW'(i)] <= wdata[i];
  always_comb
    for (int i = 0; i < 4; i++)
      rdata[i] = mem[addr + AW'(i)];
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding big-endian data memory responder with fixed wait latency
// Ports: clk; reset (sync, active-low); bus (slave modport: req_*/rsp_* handshake);
//        busy (state not IDLE). Parameter WAIT_CYCLES (0..15).
// Option: define DMEM_MISALIGN_TRAP_EN to flag misaligned/reserved-size accesses with rsp_err.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus,
  output logic                 busy
);
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic go, idle, rw_q, se_q, rw, se, wide, half, err;
  logic [1:0] size_q, size;
  logic [AW-1:0] addr_q, addr;
  logic [31:0] wdata_q, wdata, rd;
  logic [3:0] we;
  logic [3:0][7:0] lw, lr;
  assign idle = state == IDLE;
  assign bus.req_ready = idle;
  assign bus.rsp_valid = state == RESP;
  assign busy = !idle;
  // With zero wait the commit happens on the accept edge, so use the live request fields
  assign rw = idle ? bus.req_rw : rw_q;
  assign se = idle ? bus.req_se : se_q;
  assign size = idle ? bus.req_size : size_q;
  assign addr = idle ? bus.req_addr : addr_q;
  assign wdata = idle ? bus.req_wdata : wdata_q;
  assign wide = size[1];
  assign half = size == SZ_HALF;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign err = size == 2'b11 || (half && addr[0]) || (size == SZ_WORD && addr[1:0] != 2'b00);
`else
  assign err = 1'b0;
`endif
  // Lane 0 is the byte at addr, which is the most significant byte of the access
  assign lw[0] = wide ? wdata[31:24] : half ? wdata[15:8] : wdata[7:0];
  assign lw[1] = wide ? wdata[23:16] : wdata[7:0];
  assign lw[2] = wdata[15:8];
  assign lw[3] = wdata[7:0];
  assign we = (go && rw && !err && reset) ? (wide ? 4'hf : half ? 4'h3 : 4'h1) : 4'h0;
  assign rd = (rw || err) ? 32'h0 :
              wide ? {lr[0], lr[1], lr[2], lr[3]} :
              half ? {{16{se & lr[0][7]}}, lr[0], lr[1]} :
                     {{24{se & lr[0][7]}}, lr[0]};
  dmem_array u_mem (
    .clk   (clk),
    .addr  (addr),
    .we    (we),
    .wdata (lw),
    .rdata (lr)
  );
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    go = 1'b0;
    case (state)
      IDLE: if (bus.req_valid) begin
        state_n = WAIT_CYCLES == 0 ? RESP : WAIT;
        cnt_n = WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
        go = WAIT_CYCLES == 0;
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd0) begin
          state_n = RESP;
          cnt_n = 4'd0;
          go = 1'b1;
        end
      end
      RESP: if (bus.rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      bus.rsp_rdata <= 32'h0;
      bus.rsp_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (idle && bus.req_valid) begin
        rw_q <= bus.req_rw;
        se_q <= bus.req_se;
        size_q <= bus.req_size;
        addr_q <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (go) begin
        bus.rsp_rdata <= rd;
        bus.rsp_err <= err;
      end
    end
  end
endmodule
